// File: rtl/abs_diff_u4_reg.sv
// Registered unsigned absolute difference |a - b| of two packed W-bit operands.
// One-cycle latency with a valid flag; borrow and equality flags ride alongside.
module abs_diff_u4_reg #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [2*W-1:0] pi,
    output logic           out_valid,
    output logic [W-1:0]   po,
    output logic           a_lt_b,
    output logic           eq
);

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W:0]   w_d;
    logic         w_borrow;
    logic [W-1:0] w_mag;
    logic         w_eq;

    logic         r_valid;
    logic [W-1:0] r_po;
    logic         r_lt;
    logic         r_eq;

    assign w_a = pi[2*W-1:W];
    assign w_b = pi[W-1:0];

    // Extra MSB of the zero-extended subtraction is the borrow out of a - b.
    assign w_d      = {1'b0, w_a} - {1'b0, w_b};
    assign w_borrow = w_d[W];
    assign w_mag    = w_borrow ? (w_b - w_a) : w_d[W-1:0];
    assign w_eq     = (w_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_po    <= '0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_po <= w_mag;
                r_lt <= w_borrow;
                r_eq <= w_eq;
            end
        end
    end

    assign out_valid = r_valid;
    assign po        = r_po;
    assign a_lt_b    = r_lt;
    assign eq        = r_eq;

endmodule

// File: tb/tb_abs_diff_u4_reg.sv
// Directed self-checking bench for abs_diff_u4_reg.
// Observed tuple is {out_valid, a_lt_b, eq, po}.
module tb_abs_diff_u4_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] pi;
    logic       out_valid;
    logic [3:0] po;
    logic       a_lt_b;
    logic       eq;
    logic [6:0] obs;

    int errors;
    int checks;

    abs_diff_u4_reg #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pi        (pi),
        .out_valid (out_valid),
        .po        (po),
        .a_lt_b    (a_lt_b),
        .eq        (eq)
    );

    assign obs = {out_valid, a_lt_b, eq, po};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        pi       = 8'hF0;
        #1;
        checks++;
        if (obs !== 7'h00) begin
            errors++;
            $display("FAIL reset_t0 got=%h want=%h", obs, 7'h00);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'h00) begin
                errors++;
                $display("FAIL reset_hold%0d got=%h want=%h", i, obs, 7'h00);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'h00) begin
            errors++;
            $display("FAIL reset_release got=%h want=%h", obs, 7'h00);
        end
    endtask

    task automatic test_sweep(input int n);
        logic [7:0] v;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] m;
        logic [6:0] exp;
        @(negedge clk);
        in_valid = 1'b1;
        pi       = 8'h00;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            v   = 8'(i - 1);
            a   = v[7:4];
            b   = v[3:0];
            m   = (a >= b) ? 4'(a - b) : 4'(b - a);
            exp = {1'b1, a < b, a == b, m};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sweep pi=%h got=%h want=%h", v, obs, exp);
            end
            if (i < n) pi = 8'(i);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_extremes();
        logic [7:0] vec [5];
        logic [6:0] want [5];
        vec[0] = 8'h0F; want[0] = 7'b1_1_0_1111;
        vec[1] = 8'hF0; want[1] = 7'b1_0_0_1111;
        vec[2] = 8'hFF; want[2] = 7'b1_0_1_0000;
        vec[3] = 8'h05; want[3] = 7'b1_1_0_0101;
        vec[4] = 8'h44; want[4] = 7'b1_0_1_0000;
        @(negedge clk);
        in_valid = 1'b1;
        pi       = vec[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL extreme pi=%h got=%h want=%h", vec[i], obs, want[i]);
            end
            if (i < 4) pi = vec[i+1];
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1;
        pi       = 8'h36;
        @(negedge clk);
        pi = 8'h63;
        checks++;
        if (obs !== 7'b1_1_0_0011) begin
            errors++;
            $display("FAIL sym_36 got=%h want=%h", obs, 7'b1_1_0_0011);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (obs !== 7'b1_0_0_0011) begin
            errors++;
            $display("FAIL sym_63 got=%h want=%h", obs, 7'b1_0_0_0011);
        end
    endtask

    task automatic test_gap();
        @(negedge clk);
        in_valid = 1'b1;
        pi       = 8'h92;
        @(negedge clk);
        in_valid = 1'b0;
        pi       = 8'h11;
        checks++;
        if (obs !== 7'b1_0_0_0111) begin
            errors++;
            $display("FAIL gap_valid got=%h want=%h", obs, 7'b1_0_0_0111);
        end
        @(negedge clk);
        checks++;
        if (obs !== 7'b0_0_0_0111) begin
            errors++;
            $display("FAIL gap_hold got=%h want=%h", obs, 7'b0_0_0_0111);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1;
        pi       = 8'h5A;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'h00) begin
            errors++;
            $display("FAIL async_drop got=%h want=%h", obs, 7'h00);
        end
        pi = 8'hFF;
        @(negedge clk);
        checks++;
        if (obs !== 7'h00) begin
            errors++;
            $display("FAIL async_hold got=%h want=%h", obs, 7'h00);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'h00) begin
            errors++;
            $display("FAIL async_idle got=%h want=%h", obs, 7'h00);
        end
        in_valid = 1'b1;
        pi       = 8'h2A;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (obs !== 7'b1_1_0_1000) begin
            errors++;
            $display("FAIL async_first got=%h want=%h", obs, 7'b1_1_0_1000);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sweep(100);
        test_extremes();
        test_back_to_back();
        test_gap();
        test_async_reset();
        test_sweep(256);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
